// File: rtl/multi_wave_gen_if.sv
// Control and sample bus for the multi-mode waveform generator.
// The master drives the tuning and mode controls; the slave returns samples and status.
interface multi_wave_gen_if #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 24
);
  logic               en;
  logic [PHASE_W-1:0] ftw_in;
  logic               ftw_load;
  logic [1:0]         mode;
  logic [OUT_W-1:0]   duty;
  logic               phase_sync;
  logic [OUT_W-1:0]   wave_out;
  logic               wrap;
  logic               ftw_pending;

  modport master (
    output en, ftw_in, ftw_load, mode, duty, phase_sync,
    input  wave_out, wrap, ftw_pending
  );

  modport slave (
    input  en, ftw_in, ftw_load, mode, duty, phase_sync,
    output wave_out, wrap, ftw_pending
  );
endinterface

// File: rtl/multi_wave_gen.sv
// Phase-accumulator waveform generator: saw-up, saw-down, triangle and square.
// Tuning-word and mode changes take effect only on period boundaries, so waveforms stay phase-continuous.
module multi_wave_gen #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 24
) (
  input  logic           clk,
  input  logic           reset,
  multi_wave_gen_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_SAW_UP   = 2'd0,
    MODE_SAW_DOWN = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_SQUARE   = 2'd3
  } wave_mode_t;

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ftw_act;
  logic [PHASE_W-1:0] ftw_pend;
  logic [1:0]         mode_act;
  logic               pending_q;
  logic               wrap_d;
  logic               wrap_q;
  logic [OUT_W-1:0]   wave_q;

  logic [PHASE_W:0]   sum_ext;
  logic               wrap_evt;
  logic               apply_pt;
  logic [OUT_W-1:0]   p;
  logic [OUT_W-1:0]   t;
  logic [OUT_W-1:0]   sample;

  assign sum_ext  = {1'b0, acc} + {1'b0, ftw_act};
  assign wrap_evt = bus.en & ~bus.phase_sync & sum_ext[PHASE_W];
  // Period boundary: the only points where a new word or mode may take over.
  assign apply_pt = wrap_evt | bus.phase_sync;

  assign p = acc[PHASE_W-1 -: OUT_W];
  assign t = acc[PHASE_W-2 -: OUT_W];

  always_comb begin
    sample = '0;
    case (wave_mode_t'(mode_act))
      MODE_SAW_UP:   sample = p;
      MODE_SAW_DOWN: sample = ~p;
      MODE_TRIANGLE: sample = acc[PHASE_W-1] ? ~t : t;
      MODE_SQUARE:   sample = (p < bus.duty) ? {OUT_W{1'b1}} : '0;
      default:       sample = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (bus.phase_sync) begin
      acc <= '0;
    end else if (bus.en) begin
      acc <= sum_ext[PHASE_W-1:0];
    end
  end

  // A load while idle or exactly on a boundary applies at once; otherwise it is parked.
  always_ff @(posedge clk) begin
    if (reset) begin
      ftw_act   <= '0;
      ftw_pend  <= '0;
      pending_q <= 1'b0;
    end else if (bus.ftw_load && (!bus.en || apply_pt)) begin
      ftw_act   <= bus.ftw_in;
      pending_q <= 1'b0;
    end else if (bus.ftw_load) begin
      ftw_pend  <= bus.ftw_in;
      pending_q <= 1'b1;
    end else if (apply_pt && pending_q) begin
      ftw_act   <= ftw_pend;
      pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_act <= '0;
    end else if (apply_pt || !bus.en) begin
      mode_act <= bus.mode;
    end
  end

  // The wrap flag is delayed twice so it lines up with the first wrapped sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      wave_q <= '0;
      wrap_d <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      wave_q <= sample;
      wrap_d <= wrap_evt;
      wrap_q <= wrap_d;
    end
  end

  assign bus.wave_out    = wave_q;
  assign bus.wrap        = wrap_q;
  assign bus.ftw_pending = pending_q;

endmodule

// File: tb/tb_multi_wave_gen.sv
// Directed bench for multi_wave_gen at PHASE_W=32, OUT_W=24.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_multi_wave_gen;
  localparam int PHASE_W = 32;
  localparam int OUT_W   = 24;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  multi_wave_gen_if #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus ();

  multi_wave_gen #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset, then load a tuning word and mode while idle; leaves en=1 with acc=0.
  task automatic start(input logic [31:0] ftw, input logic [1:0] md);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.en = 1'b0;
    bus.ftw_in = ftw;
    bus.mode = md;
    bus.ftw_load = 1'b1;
    step();
    bus.ftw_load = 1'b0;
    bus.en = 1'b1;
  endtask

  logic [23:0] tri_exp [4];
  logic [23:0] sq_exp  [4];

  initial begin
    checks = 0;
    failures = 0;
    tri_exp = '{24'h000000, 24'h800000, 24'hFFFFFF, 24'h7FFFFF};
    sq_exp  = '{24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000};
    bus.en = 1'b1;
    bus.ftw_in = 32'hDEAD_BEEF;
    bus.ftw_load = 1'b1;
    bus.mode = 2'd3;
    bus.duty = 24'hFFFFFF;
    bus.phase_sync = 1'b0;
    reset = 1'b1;
    #2;
    step();
    check("rst_wave", 32'(bus.wave_out), 32'h0);
    check("rst_wrap", 32'(bus.wrap), 32'h0);
    check("rst_pend", 32'(bus.ftw_pending), 32'h0);
    bus.ftw_load = 1'b0;
    bus.duty = 24'h0;

    // Saw-up: step 0x010000, one wrap pulse every 256 samples on the zero sample.
    start(32'h0100_0000, 2'd0);
    for (int n = 1; n <= 260; n++) begin
      step();
      check("saw_up", 32'(bus.wave_out), ((n - 1) << 16) & 32'h00FF_FFFF);
      check("saw_up_wrap", 32'(bus.wrap), ((n > 1) && ((n - 1) % 256 == 0)) ? 32'h1 : 32'h0);
    end

    start(32'h0100_0000, 2'd1);
    for (int n = 1; n <= 8; n++) begin
      step();
      check("saw_dn", 32'(bus.wave_out), ~((n - 1) << 16) & 32'h00FF_FFFF);
    end

    start(32'h4000_0000, 2'd2);
    for (int n = 1; n <= 9; n++) begin
      step();
      check("tri", 32'(bus.wave_out), 32'(tri_exp[(n - 1) % 4]));
    end

    bus.duty = 24'h400000;
    start(32'h4000_0000, 2'd3);
    for (int n = 1; n <= 8; n++) begin
      step();
      check("sq_duty", 32'(bus.wave_out), 32'(sq_exp[(n - 1) % 4]));
    end
    bus.duty = 24'h0;
    step();
    for (int n = 0; n < 6; n++) begin
      step();
      check("sq_zero", 32'(bus.wave_out), 32'h0);
    end

    // Deferred tuning word and mode: both held until the wrap edge (step 256).
    start(32'h0100_0000, 2'd0);
    run(5);
    bus.ftw_in = 32'h0200_0000;
    bus.ftw_load = 1'b1;
    step();
    bus.ftw_load = 1'b0;
    check("dl_pend_set", 32'(bus.ftw_pending), 32'h1);
    check("dl_wave6", 32'(bus.wave_out), 32'h050000);
    run(94);
    bus.mode = 2'd1;
    step();
    check("dl_mode_held", 32'(bus.wave_out), 32'h640000);
    check("dl_pend_mid", 32'(bus.ftw_pending), 32'h1);
    run(154);
    check("dl_pend_255", 32'(bus.ftw_pending), 32'h1);
    check("dl_wave255", 32'(bus.wave_out), 32'hFE0000);
    step();
    check("dl_pend_256", 32'(bus.ftw_pending), 32'h0);
    check("dl_wave256", 32'(bus.wave_out), 32'hFF0000);
    check("dl_wrap256", 32'(bus.wrap), 32'h0);
    step();
    check("dl_wave257", 32'(bus.wave_out), 32'hFFFFFF);
    check("dl_wrap257", 32'(bus.wrap), 32'h1);
    step();
    check("dl_wave258", 32'(bus.wave_out), 32'hFDFFFF);
    check("dl_wrap258", 32'(bus.wrap), 32'h0);

    // Load coincident with the next wrap edge (step 384) applies immediately.
    run(125);
    bus.ftw_in = 32'h0400_0000;
    bus.ftw_load = 1'b1;
    bus.mode = 2'd0;
    step();
    bus.ftw_load = 1'b0;
    check("co_pend_384", 32'(bus.ftw_pending), 32'h0);
    check("co_wave384", 32'(bus.wave_out), 32'h01FFFF);
    step();
    check("co_wave385", 32'(bus.wave_out), 32'h0);
    check("co_wrap385", 32'(bus.wrap), 32'h1);
    check("co_pend_385", 32'(bus.ftw_pending), 32'h0);
    step();
    check("co_wave386", 32'(bus.wave_out), 32'h040000);

    // phase_sync mid-period applies the pending word, restarts at zero, no wrap.
    bus.ftw_in = 32'h0080_0000;
    bus.ftw_load = 1'b1;
    step();
    bus.ftw_load = 1'b0;
    check("ps_pend_set", 32'(bus.ftw_pending), 32'h1);
    bus.phase_sync = 1'b1;
    step();
    bus.phase_sync = 1'b0;
    check("ps_pend_clr", 32'(bus.ftw_pending), 32'h0);
    check("ps_wave388", 32'(bus.wave_out), 32'h0C0000);
    step();
    check("ps_wave389", 32'(bus.wave_out), 32'h0);
    check("ps_wrap389", 32'(bus.wrap), 32'h0);
    step();
    check("ps_wave390", 32'(bus.wave_out), 32'h008000);
    check("ps_wrap390", 32'(bus.wrap), 32'h0);

    // Reset with a word pending discards it; ftw_act=0 then holds acc at zero.
    bus.ftw_in = 32'h0200_0000;
    bus.ftw_load = 1'b1;
    step();
    bus.ftw_load = 1'b0;
    check("rp_pend_set", 32'(bus.ftw_pending), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rp_pend_clr", 32'(bus.ftw_pending), 32'h0);
    check("rp_wave", 32'(bus.wave_out), 32'h0);
    check("rp_wrap", 32'(bus.wrap), 32'h0);
    for (int n = 0; n < 8; n++) begin
      step();
      check("zero_ftw_wave", 32'(bus.wave_out), 32'h0);
      check("zero_ftw_wrap", 32'(bus.wrap), 32'h0);
      check("zero_ftw_pend", 32'(bus.ftw_pending), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
